// File: rtl/writeback_stage_if.sv
// Data-cache store request bus driven by the writeback stage.
// The master issues the request and holds it until the cache raises dc_wr_ready.
interface writeback_stage_if;
  logic        dc_wr_valid;
  logic        dc_wr_ready;
  logic [31:0] dc_wr_addr;
  logic [31:0] dc_wr_data;
  logic [1:0]  dc_wr_size;

  modport master (
    output dc_wr_valid,
    output dc_wr_addr,
    output dc_wr_data,
    output dc_wr_size,
    input  dc_wr_ready
  );

  modport slave (
    input  dc_wr_valid,
    input  dc_wr_addr,
    input  dc_wr_data,
    input  dc_wr_size,
    output dc_wr_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: latches the EX bundle, commits GPR/EFLAGS/ECX/EIP state and
// runs the data-cache store handshake, stalling upstream until the store is accepted.
module writeback_stage #(
  parameter logic [31:0] EFLAGS_RST = 32'h0000_0002
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_V_next,
  input  logic [31:0]       WB_NEIP_next,
  input  logic [15:0]       WB_NCS_next,
  input  logic [1:0]        WB_de_datasize_all_next,
  input  logic              WB_de_ld_gpr1_wb_next,
  input  logic              WB_de_dcache_write_wb_next,
  input  logic [6:0]        WB_de_flags_affected_wb_next,
  input  logic [31:0]       WB_ALU32_RESULT_next,
  input  logic [31:0]       WB_FLAGS_next,
  input  logic [31:0]       WB_COUNT_next,
  input  logic [31:0]       WB_ADDRESS_next,
  input  logic              WB_IS_REP_next,
  input  logic              WB_IS_REPNE_next,
  input  logic [2:0]        WB_DR1_next,
  writeback_stage_if.master dc,
  output logic              WB_stall,
  output logic              gpr_we,
  output logic [2:0]        gpr_wr_sel,
  output logic [31:0]       gpr_wr_data,
  output logic [1:0]        gpr_wr_size,
  output logic              ecx_we,
  output logic [31:0]       ecx_data,
  output logic [31:0]       eflags,
  output logic              eip_we,
  output logic [31:0]       eip_out,
  output logic [15:0]       cs_out,
  output logic              rep_redo
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e state_q, state_d;

  logic        v_q;
  logic [31:0] neip_q;
  logic [15:0] ncs_q;
  logic [1:0]  size_q;
  logic        ld_gpr1_q;
  logic        dcw_q;
  logic [6:0]  mask_q;
  logic [31:0] result_q;
  logic [31:0] flags_q;
  logic [31:0] count_q;
  logic [31:0] addr_q;
  logic        is_rep_q;
  logic        is_repne_q;
  logic [2:0]  dr1_q;

  logic [31:0] eflags_q, eflags_d;
  logic [31:0] flags_merged;
  logic [31:0] count_dec;
  logic        rep_skip;
  logic        store_req;
  logic        commit;

  // WB pipeline register; frozen while the stage stalls.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      v_q        <= 1'b0;
      neip_q     <= '0;
      ncs_q      <= '0;
      size_q     <= '0;
      ld_gpr1_q  <= 1'b0;
      dcw_q      <= 1'b0;
      mask_q     <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      is_rep_q   <= 1'b0;
      is_repne_q <= 1'b0;
      dr1_q      <= '0;
    end else if (!WB_stall) begin
      v_q        <= WB_V_next;
      neip_q     <= WB_NEIP_next;
      ncs_q      <= WB_NCS_next;
      size_q     <= WB_de_datasize_all_next;
      ld_gpr1_q  <= WB_de_ld_gpr1_wb_next;
      dcw_q      <= WB_de_dcache_write_wb_next;
      mask_q     <= WB_de_flags_affected_wb_next;
      result_q   <= WB_ALU32_RESULT_next;
      flags_q    <= WB_FLAGS_next;
      count_q    <= WB_COUNT_next;
      addr_q     <= WB_ADDRESS_next;
      is_rep_q   <= WB_IS_REP_next;
      is_repne_q <= WB_IS_REPNE_next;
      dr1_q      <= WB_DR1_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StRun;
      eflags_q <= EFLAGS_RST;
    end else begin
      state_q  <= state_d;
      eflags_q <= eflags_d;
    end
  end

  // A REP op with a zero count is a no-op apart from advancing EIP.
  always_comb begin
    rep_skip  = is_rep_q && (count_q == '0);
    store_req = v_q && dcw_q && !rep_skip;
    count_dec = (count_q != '0) ? (count_q - 32'd1) : '0;

    flags_merged     = eflags_q;
    flags_merged[0]  = mask_q[0] ? flags_q[0]  : eflags_q[0];
    flags_merged[2]  = mask_q[1] ? flags_q[2]  : eflags_q[2];
    flags_merged[4]  = mask_q[2] ? flags_q[4]  : eflags_q[4];
    flags_merged[6]  = mask_q[3] ? flags_q[6]  : eflags_q[6];
    flags_merged[7]  = mask_q[4] ? flags_q[7]  : eflags_q[7];
    flags_merged[10] = mask_q[5] ? flags_q[10] : eflags_q[10];
    flags_merged[11] = mask_q[6] ? flags_q[11] : eflags_q[11];
    flags_merged[1]  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (store_req && !dc.dc_wr_ready) state_d = StMemWait;
      StMemWait: if (dc.dc_wr_ready) state_d = StRun;
    endcase
  end

  always_comb begin
    commit   = 1'b0;
    WB_stall = 1'b0;
    unique case (state_q)
      StRun: begin
        commit   = v_q && (!store_req || dc.dc_wr_ready);
        WB_stall = store_req && !dc.dc_wr_ready;
      end
      StMemWait: begin
        commit   = dc.dc_wr_ready;
        WB_stall = !dc.dc_wr_ready;
      end
    endcase

    dc.dc_wr_valid = store_req;
    dc.dc_wr_addr  = addr_q;
    dc.dc_wr_data  = result_q;
    dc.dc_wr_size  = size_q;

    gpr_we      = commit && ld_gpr1_q && !rep_skip;
    gpr_wr_sel  = dr1_q;
    gpr_wr_data = result_q;
    gpr_wr_size = size_q;

    ecx_we   = commit && is_rep_q && !rep_skip;
    ecx_data = count_dec;
    // REPNE stops early once the freshly merged ZF is set.
    rep_redo = ecx_we && (count_dec != '0) && (!is_repne_q || !flags_merged[6]);
    eip_we   = commit && !rep_redo;
    eip_out  = neip_q;
    cs_out   = ncs_q;

    eflags_d = (commit && !rep_skip) ? flags_merged : eflags_q;
    eflags   = eflags_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: reset, ALU commit, store backpressure,
// REP/REPNE counting and reset while waiting on the data cache.
module tb_writeback_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_V_next;
  logic [31:0] WB_NEIP_next;
  logic [15:0] WB_NCS_next;
  logic [1:0]  WB_de_datasize_all_next;
  logic        WB_de_ld_gpr1_wb_next;
  logic        WB_de_dcache_write_wb_next;
  logic [6:0]  WB_de_flags_affected_wb_next;
  logic [31:0] WB_ALU32_RESULT_next;
  logic [31:0] WB_FLAGS_next;
  logic [31:0] WB_COUNT_next;
  logic [31:0] WB_ADDRESS_next;
  logic        WB_IS_REP_next;
  logic        WB_IS_REPNE_next;
  logic [2:0]  WB_DR1_next;
  logic        WB_stall;
  logic        gpr_we;
  logic [2:0]  gpr_wr_sel;
  logic [31:0] gpr_wr_data;
  logic [1:0]  gpr_wr_size;
  logic        ecx_we;
  logic [31:0] ecx_data;
  logic [31:0] eflags;
  logic        eip_we;
  logic [31:0] eip_out;
  logic [15:0] cs_out;
  logic        rep_redo;

  int vectors = 0;
  int miscompares = 0;

  writeback_stage_if dc_if ();

  writeback_stage dut (
    .CLK                          (CLK),
    .RST                          (RST),
    .WB_V_next                    (WB_V_next),
    .WB_NEIP_next                 (WB_NEIP_next),
    .WB_NCS_next                  (WB_NCS_next),
    .WB_de_datasize_all_next      (WB_de_datasize_all_next),
    .WB_de_ld_gpr1_wb_next        (WB_de_ld_gpr1_wb_next),
    .WB_de_dcache_write_wb_next   (WB_de_dcache_write_wb_next),
    .WB_de_flags_affected_wb_next (WB_de_flags_affected_wb_next),
    .WB_ALU32_RESULT_next         (WB_ALU32_RESULT_next),
    .WB_FLAGS_next                (WB_FLAGS_next),
    .WB_COUNT_next                (WB_COUNT_next),
    .WB_ADDRESS_next              (WB_ADDRESS_next),
    .WB_IS_REP_next               (WB_IS_REP_next),
    .WB_IS_REPNE_next             (WB_IS_REPNE_next),
    .WB_DR1_next                  (WB_DR1_next),
    .dc                           (dc_if),
    .WB_stall                     (WB_stall),
    .gpr_we                       (gpr_we),
    .gpr_wr_sel                   (gpr_wr_sel),
    .gpr_wr_data                  (gpr_wr_data),
    .gpr_wr_size                  (gpr_wr_size),
    .ecx_we                       (ecx_we),
    .ecx_data                     (ecx_data),
    .eflags                       (eflags),
    .eip_we                       (eip_we),
    .eip_out                      (eip_out),
    .cs_out                       (cs_out),
    .rep_redo                     (rep_redo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    WB_V_next                    = 1'b0;
    WB_NEIP_next                 = '0;
    WB_NCS_next                  = '0;
    WB_de_datasize_all_next      = '0;
    WB_de_ld_gpr1_wb_next        = 1'b0;
    WB_de_dcache_write_wb_next   = 1'b0;
    WB_de_flags_affected_wb_next = '0;
    WB_ALU32_RESULT_next         = '0;
    WB_FLAGS_next                = '0;
    WB_COUNT_next                = '0;
    WB_ADDRESS_next              = '0;
    WB_IS_REP_next               = 1'b0;
    WB_IS_REPNE_next             = 1'b0;
    WB_DR1_next                  = '0;
  endtask

  initial begin
    RST = 1'b0;
    dc_if.dc_wr_ready = 1'b0;
    clear_inputs();

    // Reset
    tick();
    tick();
    chk("rst_eflags", eflags, 32'h2);
    chk("rst_gpr_we", {31'b0, gpr_we}, 32'd0);
    chk("rst_ecx_we", {31'b0, ecx_we}, 32'd0);
    chk("rst_eip_we", {31'b0, eip_we}, 32'd0);
    chk("rst_redo", {31'b0, rep_redo}, 32'd0);
    chk("rst_dc_valid", {31'b0, dc_if.dc_wr_valid}, 32'd0);
    chk("rst_stall", {31'b0, WB_stall}, 32'd0);
    chk("rst_gpr_data", gpr_wr_data, 32'd0);
    chk("rst_eip_out", eip_out, 32'd0);

    // ALU op writing CF
    RST = 1'b1;
    WB_V_next                    = 1'b1;
    WB_de_ld_gpr1_wb_next        = 1'b1;
    WB_DR1_next                  = 3'd3;
    WB_ALU32_RESULT_next         = 32'hDEAD_BEEF;
    WB_de_flags_affected_wb_next = 7'b0000001;
    WB_FLAGS_next                = 32'hFFF;
    WB_NEIP_next                 = 32'h100;
    WB_NCS_next                  = 16'h8;
    WB_de_datasize_all_next      = 2'd2;
    tick();
    chk("alu_gpr_we", {31'b0, gpr_we}, 32'd1);
    chk("alu_gpr_sel", {29'b0, gpr_wr_sel}, 32'd3);
    chk("alu_gpr_data", gpr_wr_data, 32'hDEAD_BEEF);
    chk("alu_gpr_size", {30'b0, gpr_wr_size}, 32'd2);
    chk("alu_eip_we", {31'b0, eip_we}, 32'd1);
    chk("alu_eip_out", eip_out, 32'h100);
    chk("alu_cs_out", {16'b0, cs_out}, 32'h8);
    chk("alu_ecx_we", {31'b0, ecx_we}, 32'd0);
    chk("alu_eflags_pre", eflags, 32'h2);
    clear_inputs();
    tick();
    chk("alu_eflags_post", eflags, 32'h3);
    chk("alu_gpr_we_drop", {31'b0, gpr_we}, 32'd0);

    // Store with three cycles of backpressure
    WB_V_next                  = 1'b1;
    WB_de_dcache_write_wb_next = 1'b1;
    WB_ADDRESS_next            = 32'h1000;
    WB_ALU32_RESULT_next       = 32'h1234_5678;
    WB_de_datasize_all_next    = 2'd1;
    WB_NEIP_next               = 32'h104;
    tick();
    // Garbage on the inputs must not reach the held latch.
    WB_ADDRESS_next       = 32'h2000;
    WB_ALU32_RESULT_next  = 32'hBAD0_BAD0;
    WB_de_ld_gpr1_wb_next = 1'b1;
    WB_NEIP_next          = 32'h999;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      chk($sformatf("st_valid_c%0d", c), {31'b0, dc_if.dc_wr_valid}, 32'd1);
      chk($sformatf("st_stall_c%0d", c), {31'b0, WB_stall}, 32'd1);
      chk($sformatf("st_addr_c%0d", c), dc_if.dc_wr_addr, 32'h1000);
      chk($sformatf("st_data_c%0d", c), dc_if.dc_wr_data, 32'h1234_5678);
      chk($sformatf("st_eip_we_c%0d", c), {31'b0, eip_we}, 32'd0);
    end
    clear_inputs();
    dc_if.dc_wr_ready = 1'b1;
    #1;
    chk("st_c4_valid", {31'b0, dc_if.dc_wr_valid}, 32'd1);
    chk("st_c4_size", {30'b0, dc_if.dc_wr_size}, 32'd1);
    chk("st_c4_stall", {31'b0, WB_stall}, 32'd0);
    chk("st_c4_eip_we", {31'b0, eip_we}, 32'd1);
    chk("st_c4_eip_out", eip_out, 32'h104);
    chk("st_c4_gpr_we", {31'b0, gpr_we}, 32'd0);
    tick();
    dc_if.dc_wr_ready = 1'b0;
    #1;
    chk("st_done_valid", {31'b0, dc_if.dc_wr_valid}, 32'd0);
    chk("st_done_stall", {31'b0, WB_stall}, 32'd0);
    chk("st_eflags", eflags, 32'h3);

    // REP counting 2 -> 1 -> 0
    WB_V_next      = 1'b1;
    WB_IS_REP_next = 1'b1;
    WB_COUNT_next  = 32'd2;
    WB_NEIP_next   = 32'h200;
    tick();
    chk("rep2_ecx_we", {31'b0, ecx_we}, 32'd1);
    chk("rep2_ecx_data", ecx_data, 32'd1);
    chk("rep2_redo", {31'b0, rep_redo}, 32'd1);
    chk("rep2_eip_we", {31'b0, eip_we}, 32'd0);
    WB_COUNT_next = 32'd1;
    tick();
    chk("rep1_ecx_we", {31'b0, ecx_we}, 32'd1);
    chk("rep1_ecx_data", ecx_data, 32'd0);
    chk("rep1_redo", {31'b0, rep_redo}, 32'd0);
    chk("rep1_eip_we", {31'b0, eip_we}, 32'd1);
    WB_COUNT_next                = 32'd0;
    WB_de_ld_gpr1_wb_next        = 1'b1;
    WB_de_dcache_write_wb_next   = 1'b1;
    WB_de_flags_affected_wb_next = 7'b0000001;
    WB_FLAGS_next                = 32'h0;
    tick();
    chk("rep0_ecx_we", {31'b0, ecx_we}, 32'd0);
    chk("rep0_gpr_we", {31'b0, gpr_we}, 32'd0);
    chk("rep0_dc_valid", {31'b0, dc_if.dc_wr_valid}, 32'd0);
    chk("rep0_stall", {31'b0, WB_stall}, 32'd0);
    chk("rep0_eip_we", {31'b0, eip_we}, 32'd1);
    chk("rep0_redo", {31'b0, rep_redo}, 32'd0);
    clear_inputs();
    tick();
    chk("rep0_eflags", eflags, 32'h3);

    // REPNE terminating on ZF=1
    WB_V_next                    = 1'b1;
    WB_IS_REP_next               = 1'b1;
    WB_IS_REPNE_next             = 1'b1;
    WB_COUNT_next                = 32'd5;
    WB_de_flags_affected_wb_next = 7'b0001000;
    WB_FLAGS_next                = 32'h40;
    tick();
    chk("repne_ecx_we", {31'b0, ecx_we}, 32'd1);
    chk("repne_ecx_data", ecx_data, 32'd4);
    chk("repne_redo", {31'b0, rep_redo}, 32'd0);
    chk("repne_eip_we", {31'b0, eip_we}, 32'd1);
    clear_inputs();
    WB_de_dcache_write_wb_next = 1'b1;
    tick();
    chk("repne_eflags", eflags, 32'h43);
    chk("v0_store_valid", {31'b0, dc_if.dc_wr_valid}, 32'd0);
    chk("v0_store_stall", {31'b0, WB_stall}, 32'd0);

    // Reset while waiting on the cache
    clear_inputs();
    WB_V_next                  = 1'b1;
    WB_de_dcache_write_wb_next = 1'b1;
    WB_de_ld_gpr1_wb_next      = 1'b1;
    WB_ADDRESS_next            = 32'h3000;
    tick();
    chk("mw_valid", {31'b0, dc_if.dc_wr_valid}, 32'd1);
    tick();
    chk("mw_stall", {31'b0, WB_stall}, 32'd1);
    RST = 1'b0;
    clear_inputs();
    tick();
    chk("mwrst_valid", {31'b0, dc_if.dc_wr_valid}, 32'd0);
    chk("mwrst_stall", {31'b0, WB_stall}, 32'd0);
    chk("mwrst_gpr_we", {31'b0, gpr_we}, 32'd0);
    chk("mwrst_eip_we", {31'b0, eip_we}, 32'd0);
    chk("mwrst_eflags", eflags, 32'h2);
    RST = 1'b1;
    tick();
    chk("mwrst_after_valid", {31'b0, dc_if.dc_wr_valid}, 32'd0);
    chk("mwrst_after_eip_we", {31'b0, eip_we}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; consumes the WB_*_next bundle produced by the execute stage.
- Latches that bundle into the WB pipeline register.
- Commits architectural state: GPR write, EFLAGS merge, ECX update for REP strings, EIP/CS update.
- Performs the data-cache store handshake and stalls upstream until the store is accepted.

Parameters:
EFLAGS_RST, 32'h0000_0002, EFLAGS reset value (bit 1 reserved, reads 1)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-low reset
WB_V_next  in  1  valid from EX
WB_NEIP_next  in  32  next EIP
WB_NCS_next  in  16  next CS
WB_de_datasize_all_next  in  2  0=8b,1=16b,2=32b
WB_de_ld_gpr1_wb_next  in  1  write result to GPR DR1
WB_de_dcache_write_wb_next  in  1  store result to memory
WB_de_flags_affected_wb_next  in  7  update mask {OF,DF,SF,ZF,AF,PF,CF} (bit6..bit0)
WB_ALU32_RESULT_next  in  32  ALU result / store data
WB_FLAGS_next  in  32  flags computed by ALU
WB_COUNT_next  in  32  ECX value for REP
WB_ADDRESS_next  in  32  store address
WB_IS_REP_next  in  1  REP/REPNE-prefixed string op
WB_IS_REPNE_next  in  1  REPNE variant (terminate on ZF=1)
WB_DR1_next  in  3  destination GPR
dc_wr_ready  in  1  dcache accepts store this cycle
WB_stall  out  1  hold EX/WB latches
gpr_we  out  1  GPR write enable
gpr_wr_sel  out  3  GPR index
gpr_wr_data  out  32  GPR data
gpr_wr_size  out  2  GPR write size
ecx_we  out  1  ECX write enable
ecx_data  out  32  decremented count
eflags  out  32  architectural EFLAGS register
eip_we  out  1  commit NEIP/NCS
eip_out  out  32  committed EIP
cs_out  out  16  committed CS
rep_redo  out  1  re-fetch current string instruction
dc_wr_valid  out  1  store request
dc_wr_addr  out  32  store address
dc_wr_data  out  32  store data
dc_wr_size  out  2  store size

Behaviour:
- Reset (RST=0 at edge): latch V=0; FSM=RUN; eflags=EFLAGS_RST. All enables, rep_redo, dc_wr_valid and WB_stall = 0. Data outputs = 0.
- WB latch: loads all *_next inputs on each edge where WB_stall=0. Holds when WB_stall=1. *_next ignored while stalled.
- Commit outputs are combinational from the latch and FSM state.
- A valid op commits in exactly one cycle:
  - gpr_we, ecx_we, eip_we and rep_redo pulse for that cycle only.
  - eflags updates on the edge ending the commit cycle.
- FSM RUN:
  - V=0: no commit, no stall.
  - V=1 and dcache_write=0: commit this cycle.
  - V=1 and dcache_write=1: dc_wr_valid=1; addr/data/size come from the latch.
    - dc_wr_ready=1 in the same cycle: commit now, stay in RUN.
    - Otherwise: WB_stall=1, go to MEM_WAIT, no commit.
- FSM MEM_WAIT:
  - dc_wr_valid=1 and WB_stall=1.
  - Request fields stay stable until dc_wr_ready.
  - On ready: commit, WB_stall=0, return to RUN.
- Commit actions:
  - gpr_we = ld_gpr1; gpr_wr_sel = DR1; gpr_wr_data = ALU result; gpr_wr_size = datasize.
  - eflags per-bit merge: mask bits 0..6 select EFLAGS bits 0,2,4,6,7,10,11 from WB_FLAGS; unmasked bits are kept.
  - Bit 1 is forced to 1.
- REP (IS_REP=1):
  - COUNT=0: no GPR write, no store, no flag change; eip_we=1; ecx_we=0.
  - COUNT≠0: perform the op, then ecx_we=1 with ecx_data=COUNT-1.
    - If COUNT-1≠0, and (REPNE=0 or the merged ZF=0): rep_redo=1 and eip_we=0.
    - Otherwise: eip_we=1, rep_redo=0.
  - COUNT=32'h0000_0001 takes the termination path.
  - No wrap: COUNT=0 never decrements.
- Non-REP commit: eip_we=1, eip_out=NEIP, cs_out=NCS.
- Reset mid-MEM_WAIT: request dropped, no commit, FSM=RUN next cycle.
- V=0 with dcache_write=1: no store issued.

Test Plan:
- Reset: RST=0 for 2 cycles -> eflags=32'h2; all enables/valid/stall 0; latch V=0.
- ALU op: V=1, ld_gpr1=1, DR1=3, result=32'hDEAD_BEEF, mask=7'b0000001, FLAGS=32'hFFF -> same cycle gpr_we=1, sel=3; next cycle eflags=32'h3; eip_we=1.
- Store with backpressure: dcache_write=1, addr=32'h1000, dc_wr_ready low 3 cycles -> dc_wr_valid and WB_stall high 3 cycles with stable addr/data; commit on the 4th cycle; latch does not reload during the stall.
- REP count: IS_REP=1, COUNT=2 -> ecx_data=1, rep_redo=1, eip_we=0. Then COUNT=1 -> ecx_data=0, eip_we=1, rep_redo=0. Then COUNT=0 -> no ecx_we, no GPR write.
- REPNE early exit: COUNT=5, mask sets ZF, FLAGS ZF=1 -> ecx_data=4, rep_redo=0, eip_we=1.
- Reset during MEM_WAIT: drive RST=0 one cycle -> dc_wr_valid=0, WB_stall=0, no gpr_we/eip_we, eflags=32'h2.
